// File: rtl/mem_responder_pkg.sv
// Shared widths and FSM state encoding for the main-memory responder.
package mem_responder_pkg;

    localparam int CPU_INST_BITS  = 32;
    localparam int WORD_ADDR_BITS = 30;
    localparam int MEM_DATA_BITS  = 128;
    localparam int MEM_MASK_BITS  = MEM_DATA_BITS / 8;
    localparam int MEM_ADDR_BITS  = WORD_ADDR_BITS - $clog2(MEM_DATA_BITS / CPU_INST_BITS);

    typedef enum logic {
        MR_IDLE  = 1'b0,
        MR_WDATA = 1'b1
    } mr_state_t;

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth shift register of {valid, data}; reset flushes only the valid bits.
module mem_latency_pipe #(
    parameter int WIDTH  = 128,
    parameter int STAGES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES-1:0] valid_sr;
    logic [WIDTH-1:0]  data_sr [STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_sr[0] <= in_data;
        for (int i = 1; i < STAGES; i++) begin
            data_sr[i] <= data_sr[i-1];
        end
    end

    // Data is forced to zero between pulses so stale lines never leak out.
    assign out_valid = valid_sr[STAGES-1];
    assign out_data  = valid_sr[STAGES-1] ? data_sr[STAGES-1] : '0;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: byte-masked writes, in-order reads after a fixed latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS  = MEM_ADDR_BITS,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic                     mem_req_rw,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
    output logic                     mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    mr_state_t               state;
    logic [DEPTH_LOG2-1:0]   req_index;
    logic [DEPTH_LOG2-1:0]   wr_addr;
    logic [DEPTH_LOG2-1:0]   wr_index;
    logic                    cmd_fire;
    logic                    rd_fire;
    logic                    wr_en;
    logic [MEM_DATA_BITS-1:0] rd_line;
    logic                    unused_addr_bits;

    // Upper address bits are ignored, so lines alias modulo the stored depth.
    assign req_index        = mem_req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign cmd_fire = mem_req_valid & mem_req_ready;
    assign rd_fire  = reset & cmd_fire & ~mem_req_rw;
    assign wr_en    = reset & mem_req_data_valid & mem_req_data_ready &
                      ((state == MR_WDATA) | (cmd_fire & mem_req_rw));
    assign wr_index = (state == MR_WDATA) ? wr_addr : req_index;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= MR_IDLE;
            mem_req_ready      <= 1'b0;
            mem_req_data_ready <= 1'b0;
            wr_addr            <= '0;
        end else begin
            case (state)
                MR_IDLE: begin
                    mem_req_ready      <= 1'b1;
                    mem_req_data_ready <= 1'b1;
                    if (cmd_fire && mem_req_rw && !mem_req_data_valid) begin
                        wr_addr       <= req_index;
                        state         <= MR_WDATA;
                        mem_req_ready <= 1'b0;
                    end
                end
                MR_WDATA: begin
                    mem_req_ready      <= 1'b0;
                    mem_req_data_ready <= 1'b1;
                    if (mem_req_data_valid) begin
                        state         <= MR_IDLE;
                        mem_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state              <= MR_IDLE;
                    mem_req_ready      <= 1'b0;
                    mem_req_data_ready <= 1'b0;
                end
            endcase
        end
    end

    // One byte lane per bank keeps the masked write free of read-modify-write.
    for (genvar b = 0; b < MEM_MASK_BITS; b++) begin : g_byte
        logic [7:0] bank [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en && mem_req_data_mask[b]) begin
                bank[wr_index] <= mem_req_data_bits[8*b +: 8];
            end
        end

        assign rd_line[8*b +: 8] = bank[req_index];
    end

    mem_latency_pipe #(
        .WIDTH  (MEM_DATA_BITS),
        .STAGES (LATENCY)
    ) u_latency_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_fire),
        .in_data   (rd_line),
        .out_valid (mem_resp_valid),
        .out_data  (mem_resp_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with hand-computed expected lines.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT = 8;

    logic                     clk;
    logic                     reset;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_req_rw;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
    logic                     mem_resp_valid;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int spurious = 0;
    int rd_idx = 0;
    bit mon_en = 0;
    logic [127:0] rsp_data_q [$];
    int           rsp_edge_q [$];

    mem_responder #(
        .ADDR_BITS  (MEM_ADDR_BITS),
        .DEPTH_LOG2 (12),
        .LATENCY    (LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Responses are logged with the edge that raised them; data between pulses must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_resp_valid === 1'b1) begin
                rsp_data_q.push_back(mem_resp_data);
                rsp_edge_q.push_back(edge_cnt);
            end else if (mem_resp_data !== '0) begin
                spurious++;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic setIdle();
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
    endtask

    // Drives one cycle of request inputs; returns just after the edge that samples them.
    task automatic applyStimulus(input logic valid, input logic rw, input logic [27:0] addr,
                                 input logic dvalid, input logic [127:0] data,
                                 input logic [15:0] mask, output int accept_edge);
        mem_req_valid      = valid;
        mem_req_rw         = rw;
        mem_req_addr       = addr;
        mem_req_data_valid = dvalid;
        mem_req_data_bits  = data;
        mem_req_data_mask  = mask;
        @(posedge clk);
        #1;
        accept_edge = edge_cnt;
        setIdle();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectResp(input string tag, input int exp_edge, input logic [127:0] exp_data);
        int           got_edge;
        logic [127:0] got_data;
        checkOutput({tag, "_present"}, 128'(rsp_data_q.size() > rd_idx), 128'd1);
        if (rsp_data_q.size() > rd_idx) begin
            got_edge = rsp_edge_q[rd_idx];
            got_data = rsp_data_q[rd_idx];
            rd_idx++;
            checkOutput({tag, "_edge"}, 128'(got_edge), 128'(exp_edge));
            checkOutput({tag, "_data"}, got_data, exp_data);
        end
    endtask

    initial begin
        int a;
        int rd_edge [6];
        logic [127:0] line_val [6];
        logic [127:0] d1;
        logic [127:0] d4;

        d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        d4 = 128'hDEADBEEF_CAFEF00D_13572468_9ABCDEF0;
        for (int i = 0; i < 6; i++) begin
            line_val[i] = {4{32'h1000_0000 + 32'(i)}};
        end

        // Reset held for three edges, then released.
        setIdle();
        reset = 1'b0;
        waitCycles(3);
        mon_en = 1;
        checkOutput("rst_req_ready", 128'(mem_req_ready), 128'd0);
        checkOutput("rst_data_ready", 128'(mem_req_data_ready), 128'd0);
        checkOutput("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
        checkOutput("rst_resp_data", mem_resp_data, 128'd0);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("rel_req_ready", 128'(mem_req_ready), 128'd1);
        checkOutput("rel_data_ready", 128'(mem_req_data_ready), 128'd1);
        checkOutput("rel_resp_valid", 128'(mem_resp_valid), 128'd0);
        $display("[TB] reset checks done");

        // Write then read of line 0x5, read issued the very next cycle.
        applyStimulus(1, 1, 28'h5, 1, d1, 16'hFFFF, a);
        applyStimulus(1, 0, 28'h5, 0, '0, '0, a);
        waitCycles(LAT + 2);
        expectResp("wr_rd", a + LAT - 1, d1);
        checkOutput("wr_rd_single", 128'(rsp_data_q.size()), 128'(rd_idx));

        // Byte mask: only the low four bytes take the new value.
        applyStimulus(1, 1, 28'h7, 1, {16{8'hAA}}, 16'hFFFF, a);
        applyStimulus(1, 1, 28'h7, 1, {16{8'hFF}}, 16'h000F, a);
        applyStimulus(1, 0, 28'h7, 0, '0, '0, a);
        waitCycles(LAT + 2);
        expectResp("mask", a + LAT - 1, 128'hAAAAAAAAAAAAAAAAAAAAAAAAFFFFFFFF);

        // Empty mask leaves the line unchanged.
        applyStimulus(1, 1, 28'h7, 1, '0, 16'h0000, a);
        applyStimulus(1, 0, 28'h7, 0, '0, '0, a);
        waitCycles(LAT + 2);
        expectResp("mask0", a + LAT - 1, 128'hAAAAAAAAAAAAAAAAAAAAAAAAFFFFFFFF);

        // Split write: command first, data three cycles later.
        applyStimulus(1, 1, 28'h9, 0, '0, '0, a);
        checkOutput("split_ready_c1", 128'(mem_req_ready), 128'd0);
        checkOutput("split_dready_c1", 128'(mem_req_data_ready), 128'd1);
        waitCycles(1);
        checkOutput("split_ready_c2", 128'(mem_req_ready), 128'd0);
        waitCycles(1);
        checkOutput("split_ready_c3", 128'(mem_req_ready), 128'd0);
        applyStimulus(0, 0, 28'h0, 1, d4, 16'hFFFF, a);
        checkOutput("split_ready_back", 128'(mem_req_ready), 128'd1);
        // Data with no write command in IDLE must be dropped.
        applyStimulus(0, 1, 28'h9, 1, {16{8'h55}}, 16'hFFFF, a);
        applyStimulus(1, 0, 28'h9, 0, '0, '0, a);
        waitCycles(LAT + 2);
        expectResp("split_rd", a + LAT - 1, d4);

        // Streaming: fill lines 0..5, then six back-to-back reads.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 28'(i), 1, line_val[i], 16'hFFFF, a);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 28'(i), 0, '0, '0, rd_edge[i]);
        end
        waitCycles(LAT + 2);
        for (int i = 0; i < 6; i++) begin
            expectResp($sformatf("stream%0d", i), rd_edge[i] + LAT - 1, line_val[i]);
        end
        applyStimulus(1, 0, 28'h1005, 0, '0, '0, a);
        waitCycles(LAT + 2);
        expectResp("alias", a + LAT - 1, line_val[5]);

        // A write landing behind an in-flight read must not change that read.
        applyStimulus(1, 0, 28'h3, 0, '0, '0, a);
        rd_edge[0] = a;
        applyStimulus(1, 1, 28'h3, 1, {16{8'h3C}}, 16'hFFFF, a);
        applyStimulus(1, 0, 28'h3, 0, '0, '0, a);
        waitCycles(LAT + 2);
        expectResp("inflight_old", rd_edge[0] + LAT - 1, line_val[3]);
        expectResp("inflight_new", a + LAT - 1, {16{8'h3C}});

        // Reset with three reads in flight drops them and keeps the array.
        applyStimulus(1, 0, 28'h0, 0, '0, '0, a);
        applyStimulus(1, 0, 28'h1, 0, '0, '0, a);
        applyStimulus(1, 0, 28'h2, 0, '0, '0, a);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(2);
        checkOutput("midrst_req_ready", 128'(mem_req_ready), 128'd0);
        reset = 1'b1;
        waitCycles(LAT + 6);
        checkOutput("midrst_no_pulse", 128'(rsp_data_q.size()), 128'(rd_idx));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 28'(i), 0, '0, '0, rd_edge[i]);
        end
        waitCycles(LAT + 2);
        for (int i = 0; i < 3; i++) begin
            expectResp($sformatf("retain%0d", i), rd_edge[i] + LAT - 1, line_val[i]);
        end

        checkOutput("no_extra_pulses", 128'(rsp_data_q.size()), 128'(rd_idx));
        checkOutput("idle_data_zero", 128'(spurious), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
